// File: rtl/rv_pkg.sv
// Shared definitions for the core's load/store path: funct3 codes, the data
// memory controller's state enum and the byte-lane mask helper.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Byte enables touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: return 4'b0001 << a;
      F3_H, F3_HU: return a[1] ? 4'b1100 : 4'b0011;
      F3_W:        return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
// Contents are never reset.
module dmem_bram #(
  parameter int    DEPTH_WORDS = 64,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Load/store controller in front of the data RAM: req/rsp handshake, programmable
// wait states, byte/half/word lanes, load extension and access-error reporting.
module dmem_wait_ctrl
  import rv_pkg::*;
#(
  parameter int    XLEN        = 32,
  parameter int    DEPTH_WORDS = 64,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            stall
);

  localparam int              AW       = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] ADDR_LIM = XLEN'(4 * DEPTH_WORDS);

  generate
    if (XLEN != 32) begin : g_xlen_chk
      $error("dmem_wait_ctrl supports XLEN=32 only");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
      $error("dmem_wait_ctrl WAIT_STATES must be 0..15");
    end
  endgenerate

  dmem_state_e     state;
  logic [3:0]      cnt;
  logic            lat_we;
  logic [2:0]      lat_f3;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;

  logic            accept;
  logic            commit;
  logic            cur_we;
  logic [2:0]      cur_f3;
  logic [XLEN-1:0] cur_addr;
  logic [XLEN-1:0] cur_wdata;
  logic            cur_err;
  logic [3:0]      ram_be;
  logic            ram_re;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;
  logic [7:0]      rd_b;
  logic [15:0]     rd_h;

  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [XLEN-1:0] a);
    logic bad_f3;
    logic misalign;
    if (we) bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
    else    bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misalign = ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && a[1:0] != 2'b00);
    return bad_f3 || misalign || (a >= ADDR_LIM);
  endfunction

  assign req_ready = (state == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign stall     = req_valid && !rsp_valid;

  // A zero-wait access commits on the accept edge itself, so it must use the live request.
  assign cur_we    = (state == IDLE) ? req_we     : lat_we;
  assign cur_f3    = (state == IDLE) ? req_funct3 : lat_f3;
  assign cur_addr  = (state == IDLE) ? req_addr   : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata  : lat_wdata;
  assign cur_err   = access_err(cur_we, cur_f3, cur_addr);

  assign commit = (state == IDLE) ? (accept && WAIT_STATES == 0)
                                  : (state == WAIT && cnt == 4'd0);
  assign ram_be = (commit && cur_we && !cur_err) ? lane_mask(cur_f3, cur_addr[1:0]) : 4'b0000;
  assign ram_re = commit && !cur_we && !cur_err;

  always_comb begin
    case (cur_f3)
      F3_B:    ram_wdata = {4{cur_wdata[7:0]}};
      F3_H:    ram_wdata = {2{cur_wdata[15:0]}};
      default: ram_wdata = cur_wdata;
    endcase
  end

  dmem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_bram (
    .clk   (clk),
    .be    (ram_be),
    .re    (ram_re),
    .addr  (cur_addr[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_f3    <= req_funct3;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= cur_err;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= cur_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM output register holds the loaded word during RESP; only alignment is left.
  assign rd_b = 8'(ram_rdata >> {lat_addr[1:0], 3'b000});
  assign rd_h = lat_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid && !rsp_err && !lat_we) begin
      case (lat_f3)
        F3_B:    rsp_rdata = {{24{rd_b[7]}}, rd_b};
        F3_BU:   rsp_rdata = {24'd0, rd_b};
        F3_H:    rsp_rdata = {{16{rd_h[15]}}, rd_h};
        F3_HU:   rsp_rdata = {16'd0, rd_h};
        F3_W:    rsp_rdata = ram_rdata;
        default: rsp_rdata = '0;
      endcase
    end
  end

endmodule
